// File: rtl/vco_freq_meter_if.sv
// Sample stream in, period/amplitude reports out, for the VCO frequency meter.
interface vco_freq_meter_if #(
    parameter int W     = 14,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic signed [W-1:0]  x;
    logic                 period_valid;
    logic [CNT_W-1:0]     period;
    logic signed [W-1:0]  amp;
    logic                 timeout;

    // Sample source side
    modport master (
        output in_valid, x,
        input  period_valid, period, amp, timeout
    );

    // Meter side
    modport slave (
        input  in_valid, x,
        output period_valid, period, amp, timeout
    );
endinterface

// File: rtl/vco_freq_meter.sv
// Measures the averaged period and peak amplitude of a signed sample stream.
// A hysteresis comparator finds rising zero crossings; valid samples between
// crossings are counted and summed over 2^LOG2_NPER periods per report.
module vco_freq_meter #(
    parameter int W         = 14,
    parameter int CNT_W     = 16,
    parameter int LOG2_NPER = 2,
    parameter int HYST      = 64
) (
    input  logic            clk,
    input  logic            reset,
    vco_freq_meter_if.slave bus
);
    localparam int SUM_W = CNT_W + LOG2_NPER;
    localparam logic signed [W-1:0]  HYST_P    = W'(HYST);
    localparam logic signed [W-1:0]  HYST_N    = -HYST_P;
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [LOG2_NPER-1:0] NPER_LAST = {LOG2_NPER{1'b1}};

    typedef enum logic [0:0] {
        ST_SEEK    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic                   lvl_r, lvl_nxt_s;
    logic                   lvl_known_r, lvl_known_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [SUM_W-1:0]       sum_r, sum_nxt_s;
    logic [LOG2_NPER-1:0]   nper_r, nper_nxt_s;
    logic signed [W-1:0]    amp_acc_r, amp_acc_nxt_s;
    logic [CNT_W-1:0]       period_r, period_nxt_s;
    logic signed [W-1:0]    amp_r, amp_nxt_s;
    logic                   period_valid_r, period_valid_nxt_s;
    logic                   timeout_r, timeout_nxt_s;

    logic                   hi_s, lo_s, rise_s, window_done_s;
    logic [CNT_W:0]         cnt_inc_s;
    logic [SUM_W:0]         win_sum_s;
    logic [SUM_W:0]         period_shift_s;
    logic signed [W-1:0]    amp_max_s;

    // Comparator, crossing detector and shared arithmetic
    assign hi_s           = (bus.x >= HYST_P);
    assign lo_s           = (bus.x < HYST_N);
    assign rise_s         = bus.in_valid & hi_s & lvl_known_r & ~lvl_r;
    assign cnt_inc_s      = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign win_sum_s      = {1'b0, sum_r} + {{LOG2_NPER{1'b0}}, cnt_inc_s};
    assign period_shift_s = win_sum_s >> LOG2_NPER;
    assign amp_max_s      = (bus.x > amp_acc_r) ? bus.x : amp_acc_r;
    assign window_done_s  = (nper_r == NPER_LAST);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_SEEK;
            lvl_r          <= 1'b0;
            lvl_known_r    <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            sum_r          <= {SUM_W{1'b0}};
            nper_r         <= {LOG2_NPER{1'b0}};
            amp_acc_r      <= {W{1'b0}};
            period_r       <= {CNT_W{1'b0}};
            amp_r          <= {W{1'b0}};
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            lvl_r          <= lvl_nxt_s;
            lvl_known_r    <= lvl_known_nxt_s;
            cnt_r          <= cnt_nxt_s;
            sum_r          <= sum_nxt_s;
            nper_r         <= nper_nxt_s;
            amp_acc_r      <= amp_acc_nxt_s;
            period_r       <= period_nxt_s;
            amp_r          <= amp_nxt_s;
            period_valid_r <= period_valid_nxt_s;
            timeout_r      <= timeout_nxt_s;
        end
    end

    // Next-state: arm on a rising event, fall back to SEEK on counter timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SEEK: begin
                if (rise_s) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_SEEK;
                end
            end
            ST_MEASURE: begin
                if (bus.in_valid && !rise_s && (cnt_r == CNT_MAX)) begin
                    state_nxt_s = ST_SEEK;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            default: state_nxt_s = ST_SEEK;
        endcase
    end

    // Level tracker, period accumulation and report outputs
    always_comb begin
        lvl_nxt_s          = lvl_r;
        lvl_known_nxt_s    = lvl_known_r;
        cnt_nxt_s          = cnt_r;
        sum_nxt_s          = sum_r;
        nper_nxt_s         = nper_r;
        amp_acc_nxt_s      = amp_acc_r;
        period_nxt_s       = period_r;
        amp_nxt_s          = amp_r;
        period_valid_nxt_s = 1'b0;
        timeout_nxt_s      = 1'b0;

        // Samples inside the band leave the level untouched
        if (bus.in_valid && hi_s) begin
            lvl_nxt_s       = 1'b1;
            lvl_known_nxt_s = 1'b1;
        end else if (bus.in_valid && lo_s) begin
            lvl_nxt_s       = 1'b0;
            lvl_known_nxt_s = 1'b1;
        end else begin
            lvl_nxt_s       = lvl_r;
            lvl_known_nxt_s = lvl_known_r;
        end

        case (state_r)
            ST_SEEK: begin
                if (rise_s) begin
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    sum_nxt_s     = {SUM_W{1'b0}};
                    nper_nxt_s    = {LOG2_NPER{1'b0}};
                    amp_acc_nxt_s = bus.x;
                end else begin
                    cnt_nxt_s     = cnt_r;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (window_done_s) begin
                        // The event sample closes this window and opens the next
                        period_nxt_s       = period_shift_s[CNT_W-1:0];
                        amp_nxt_s          = amp_max_s;
                        period_valid_nxt_s = 1'b1;
                        sum_nxt_s          = {SUM_W{1'b0}};
                        nper_nxt_s         = {LOG2_NPER{1'b0}};
                        amp_acc_nxt_s      = bus.x;
                    end else begin
                        sum_nxt_s          = win_sum_s[SUM_W-1:0];
                        nper_nxt_s         = nper_r + LOG2_NPER'(1'b1);
                        amp_acc_nxt_s      = amp_max_s;
                    end
                end else if (bus.in_valid) begin
                    amp_acc_nxt_s = amp_max_s;
                    if (cnt_r == CNT_MAX) begin
                        timeout_nxt_s = 1'b1;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        sum_nxt_s     = {SUM_W{1'b0}};
                        nper_nxt_s    = {LOG2_NPER{1'b0}};
                    end else begin
                        cnt_nxt_s     = cnt_inc_s[CNT_W-1:0];
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    assign bus.period_valid = period_valid_r;
    assign bus.period       = period_r;
    assign bus.amp          = amp_r;
    assign bus.timeout      = timeout_r;
endmodule

// File: tb/tb_vco_freq_meter.sv
// Scoreboard bench for vco_freq_meter: expected reports/timeouts are queued
// as stimulus is driven and matched against DUT pulses on the falling edge.
module tb_vco_freq_meter;
    localparam int W     = 14;
    localparam int CNT_W = 16;

    typedef struct {
        bit     is_to;
        int     per;
        int     amp;
        bit     tol;
        real    per_ref;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_pv     = 0;
    int     n_to     = 0;
    exp_t   sb[$];
    longint pv_times[$];

    // VCO model and bench-side crossing tracker state
    int vx, vy;
    bit tk, tl;

    vco_freq_meter_if #(.W(W), .CNT_W(CNT_W)) bus ();

    vco_freq_meter #(.W(W), .CNT_W(CNT_W), .LOG2_NPER(2), .HYST(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        real  d;
        if (bus.period_valid && bus.timeout) check_val("pv_to_overlap", 1, 0);
        if (bus.period_valid || bus.timeout) begin
            if (bus.period_valid) begin
                n_pv++;
                pv_times.push_back(cyc);
            end
            if (bus.timeout) n_to++;
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", {bus.period_valid, bus.timeout}, 0);
            end else begin
                e = sb.pop_front();
                check_val("pulse_kind", bus.timeout, e.is_to);
                check_val("latency", cyc, e.cyc);
                if (bus.period_valid && e.tol) begin
                    d = real'(bus.period) - e.per_ref;
                    check_val("vco_period_pm1", (d <= 1.0 && d >= -1.0), 1);
                end else if (bus.period_valid) begin
                    check_val("period", bus.period, e.per);
                    check_val("amp", $signed(bus.amp), e.amp);
                end
            end
        end
    end

    task automatic send(input int v, input int gap);
        bus.in_valid = 1'b1;
        bus.x        = W'(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input bit is_to, input int per, input int amp,
                            input bit tol, input real per_ref);
        exp_t e;
        e.is_to   = is_to;
        e.per     = per;
        e.amp     = amp;
        e.tol     = tol;
        e.per_ref = per_ref;
        e.cyc     = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.x        = '0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_period", bus.period, 0);
        check_val("rst_amp", bus.amp, 0);
        check_val("rst_pv", bus.period_valid, 0);
        check_val("rst_to", bus.timeout, 0);
        pv_times.delete();
    endtask

    task automatic drain(input string tag);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val(tag, sb.size(), 0);
    endtask

    // One oscillation period: first sample is the rising event, peak at index 2
    task automatic wave(input int p, input int pos, input int peak, input int neg, input int gap);
        int h = p / 2;
        for (int i = 0; i < p; i++) begin
            send((i < h) ? ((i == 2) ? peak : pos) : neg, gap);
        end
    endtask

    task automatic square_run(input int gap, input longint spacing, input string tag);
        do_reset();
        for (int k = 0; k < 18; k++) begin
            if (k >= 5 && ((k - 1) % 4) == 0) push_exp(1'b0, 16, 1000, 1'b0, 0.0);
            wave(16, 1000, 1000, -1000, gap);
        end
        drain({tag, "_pending"});
        check_val({tag, "_reports"}, pv_times.size(), 4);
        if (pv_times.size() == 4) begin
            for (int i = 1; i < 4; i++) check_val({tag, "_spacing"}, pv_times[i] - pv_times[i-1], spacing);
        end
    endtask

    task automatic vco_step();
        vx = vx - (vy >>> 3);
        vy = vy + (vx >>> 3);
    endtask

    // Bench-side hysteresis crossing detector on the current VCO sample
    function automatic bit track_event(input int v);
        bit ev = 1'b0;
        if (v >= 64) begin
            ev = tk && !tl;
            tl = 1'b1;
            tk = 1'b1;
        end else if (v < -64) begin
            tl = 1'b0;
            tk = 1'b1;
        end
        return ev;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p4[8]  = '{15, 16, 17, 16, 15, 15, 15, 16};
        int pk4[8] = '{900, 1200, 1100, 1000, 700, 800, 600, 750};
        int n0_pv, n0_to, ev, phase, first, last, ncross, prev;
        bit is_ev, stop;
        real per_ref;

        bus.in_valid = 1'b0;
        bus.x        = '0;
        reset        = 1'b1;
        @(posedge clk);
        #1;

        // Continuous square wave, then the same stream at half rate
        square_run(0, 64, "sq");
        square_run(1, 128, "sq_half");

        // In-band triangle never produces an event
        do_reset();
        n0_pv = n_pv;
        n0_to = n_to;
        for (int r = 0; r < 20; r++) begin
            for (int v = -30; v <= 30; v += 5) send(v, 0);
            for (int v = 25; v >= -25; v -= 5) send(v, 0);
        end
        drain("tri_pending");
        check_val("tri_no_pv", n_pv - n0_pv, 0);
        check_val("tri_no_to", n_to - n0_to, 0);
        check_val("tri_period", bus.period, 0);
        check_val("tri_amp", bus.amp, 0);

        // Uneven periods and peaks: 64>>2=16 with peak 1200, then 61>>2=15 with 800
        do_reset();
        repeat (4) send(-800, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) push_exp(1'b0, 16, 1200, 1'b0, 0.0);
            wave(p4[i], 500, pk4[i], -800, 0);
        end
        push_exp(1'b0, 15, 800, 1'b0, 0.0);
        send(500, 0);
        drain("seq_pending");

        // Arm, then stay high until the counter runs out
        do_reset();
        send(-1000, 0);
        send(1000, 0);
        for (int i = 1; i <= 65536; i++) begin
            if (i == 65536) push_exp(1'b1, 0, 0, 1'b0, 0.0);
            send(1000, 0);
        end
        repeat (8) send(-1000, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) push_exp(1'b0, 16, 1000, 1'b0, 0.0);
            wave(16, 1000, 1000, -1000, 0);
        end
        drain("to_pending");
        check_val("to_count", n_to, 1);

        // Reference period of the VCO model from its zero crossings
        vx = 6471;
        vy = 0;
        prev = vx;
        first = -1;
        last = 0;
        ncross = 0;
        for (int i = 0; i < 4000; i++) begin
            vco_step();
            if (prev < 0 && vx >= 0) begin
                if (first < 0) first = i;
                last = i;
                ncross++;
            end
            prev = vx;
        end
        per_ref = real'(last - first) / real'(ncross - 1);

        // VCO stream with a reset two periods into the first window
        do_reset();
        vx = 6471;
        vy = 0;
        tk = 1'b0;
        tl = 1'b0;
        ev = 0;
        phase = 0;
        stop = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            is_ev = track_event(vx);
            if (is_ev) ev++;
            if (phase == 1 && is_ev && ev == 5) push_exp(1'b0, 0, 0, 1'b1, per_ref);
            send(vx, 0);
            vco_step();
            if (phase == 0 && ev == 3) begin
                do_reset();
                phase = 1;
                ev = 0;
                tk = 1'b0;
                tl = 1'b0;
            end else if (phase == 1 && ev == 5) begin
                stop = 1'b1;
            end
            if (stop) break;
        end
        drain("vco_pending");
        check_val("vco_reached_report", stop, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
